// File: rtl/ram_rd_seq_if.sv
// Purpose : bundles the request, row-RAM read port and output stream of ram_rd_seq.
// Latency : none, wiring only.
// Backpressure: out_ready is driven by the consumer; the sequencer stalls reads against it.
// Ports:
//   start/fwd_inv/len  - row request (master -> slave)
//   mem_addr/mem_re    - row-RAM read strobe and address (slave -> master)
//   mem_dout           - row-RAM read data, one cycle after mem_re (master -> slave)
//   out_*              - sample stream with subband tag and end-of-row marker
//   busy/done          - row status
interface ram_rd_seq_if #(
  parameter int W  = 26,
  parameter int AW = 7
);
  logic          start;
  logic          fwd_inv;
  logic [AW-1:0] len;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [W-1:0]  mem_dout;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sb;
  logic          out_last;
  logic          busy;
  logic          done;

  // Requester / RAM / consumer side.
  modport master (
    output start, fwd_inv, len, mem_dout, out_ready,
    input  mem_addr, mem_re, out_data, out_valid, out_sb, out_last, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, fwd_inv, len, mem_dout, out_ready,
    output mem_addr, mem_re, out_data, out_valid, out_sb, out_last, busy, done
  );
endinterface

// File: rtl/ram_rd_seq.sv
// Purpose : reads one row of a row-RAM in natural or deinterleaved (evens then odds) order.
// Latency : start edge k -> first read in cycle k..k+1 -> out_valid after edge k+2; 1 beat/cycle sustained.
// Backpressure: 2-entry output buffer; reads are issued only while buffer + in-flight read stays below 2.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - ram_rd_seq_if.slave: request (start/fwd_inv/len), RAM read port
//                (mem_addr/mem_re/mem_dout), stream (out_data/out_valid/out_ready/
//                out_sb/out_last), status (busy/done)
module ram_rd_seq #(
  parameter int W  = 26,
  parameter int AW = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_rd_seq_if.slave bus
);

  // One extra bit so a full row (len=0 -> 2**AW) and the read count never wrap.
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_inv;
  logic [CW-1:0] r_n;
  logic [CW-1:0] r_rd_cnt;

  // Tag of the read whose data arrives on mem_dout this cycle.
  logic          r_if_vld;
  logic          r_if_sb;
  logic          r_if_last;

  // Output buffer, slot 0 is the head presented on the stream.
  logic [W-1:0]  r_dat0;
  logic [W-1:0]  r_dat1;
  logic          r_sb0;
  logic          r_sb1;
  logic          r_last0;
  logic          r_last1;
  logic [1:0]    r_occ;
  logic          r_done;

  logic          w_start;
  logic          w_xfer;
  logic          w_pop_last;
  logic          w_room;
  logic          w_re;
  logic          w_last_rd;
  logic [CW-1:0] w_half;
  logic [CW-1:0] w_addr;
  logic [2:0]    w_pend;
  logic [1:0]    w_wr_pos;

  always_comb begin
    w_start    = (r_state == S_IDLE) && bus.start;
    w_xfer     = (r_occ != 2'd0) && bus.out_ready;
    w_pop_last = w_xfer && r_last0;

    // Deinterleaved: first ceil(N/2) reads walk the evens, the rest walk the odds.
    w_half = (r_n + CW'(1)) >> 1;
    if (!r_inv)
      w_addr = r_rd_cnt;
    else if (r_rd_cnt < w_half)
      w_addr = r_rd_cnt << 1;
    else
      w_addr = ((r_rd_cnt - w_half) << 1) | CW'(1);

    // Occupancy after this edge's pop, counting the read already in flight.
    w_pend    = 3'(r_occ) + 3'(r_if_vld) - 3'(w_xfer);
    w_room    = w_pend < 3'd2;
    w_re      = (r_state == S_RUN) && (r_rd_cnt < r_n) && w_room;
    w_last_rd = (r_rd_cnt == (r_n - CW'(1)));

    // Arriving data lands behind whatever survives this edge's pop.
    w_wr_pos  = r_occ - 2'(w_xfer);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start)          w_state_nxt = S_RUN;
      S_RUN:   if (w_re && w_last_rd)  w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop_last)         w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_inv     <= 1'b0;
      r_n       <= '0;
      r_rd_cnt  <= '0;
      r_if_vld  <= 1'b0;
      r_if_sb   <= 1'b0;
      r_if_last <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= (r_state == S_DRAIN) && w_pop_last;
      r_if_vld  <= w_re;
      r_if_sb   <= w_addr[0];
      r_if_last <= w_last_rd;
      if (w_start) begin
        r_inv    <= bus.fwd_inv;
        r_n      <= (bus.len == '0) ? CW'(1 << AW) : CW'(bus.len);
        r_rd_cnt <= '0;
      end else if (w_re) begin
        r_rd_cnt <= r_rd_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat0  <= '0;
      r_dat1  <= '0;
      r_sb0   <= 1'b0;
      r_sb1   <= 1'b0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_occ   <= 2'd0;
    end else begin
      if (w_xfer) begin
        r_dat0  <= r_dat1;
        r_sb0   <= r_sb1;
        r_last0 <= r_last1;
      end
      // A write to slot 0 here overrides the shift above, which is the intent.
      if (r_if_vld) begin
        if (w_wr_pos == 2'd0) begin
          r_dat0  <= bus.mem_dout;
          r_sb0   <= r_if_sb;
          r_last0 <= r_if_last;
        end else begin
          r_dat1  <= bus.mem_dout;
          r_sb1   <= r_if_sb;
          r_last1 <= r_if_last;
        end
      end
      r_occ <= w_wr_pos + 2'(r_if_vld);
    end
  end

  assign bus.mem_re    = w_re;
  assign bus.mem_addr  = w_re ? AW'(w_addr) : '0;
  assign bus.out_valid = (r_occ != 2'd0);
  assign bus.out_data  = r_dat0;
  assign bus.out_sb    = r_sb0;
  assign bus.out_last  = r_last0;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;

endmodule

// File: tb/tb_ram_rd_seq.sv
// Purpose : directed bench for ram_rd_seq with a 1-cycle row-RAM model and a stream monitor.
// Latency : checks start-to-first-read, first-valid, last-transfer and done timing.
// Backpressure: out_ready held high, held low, or randomised per scenario.
module tb_ram_rd_seq;
  localparam int W  = 26;
  localparam int AW = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  ram_rd_seq_if #(.W(W), .AW(AW)) bus ();
  ram_rd_seq #(.W(W), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;
  int rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
  int clr_tok  = 0;

  logic [W-1:0] ram [128];

  function automatic logic [W-1:0] pat(input int a);
    logic [31:0] v;
    v = a * 32'h20401;
    return v[W-1:0] ^ 26'h2A00000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_re) bus.mem_dout <= ram[bus.mem_addr];

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Stream monitor, sampled on the falling edge.
  logic [W-1:0] q_dat [$];
  logic         q_sb [$];
  logic         q_last [$];
  int           q_addr [$];
  int first_re = -1, first_vld = -1, last_edge = -1, done_edge = -1;
  int done_cnt = 0, issued = 0, xferred = 0, ovf = 0, unstable = 0, m_tok = 0;
  logic m_x, m_hold = 1'b0;
  logic [W+1:0] m_prev;

  always @(negedge clk) begin
    m_x = bus.out_valid && bus.out_ready;
    if (m_hold && (!bus.out_valid || {bus.out_data, bus.out_sb, bus.out_last} !== m_prev))
      unstable++;
    m_hold = bus.out_valid && !bus.out_ready;
    m_prev = {bus.out_data, bus.out_sb, bus.out_last};
    if (bus.mem_re) begin
      if (issued - xferred - int'(m_x) >= 2) ovf++;
      if (first_re < 0) first_re = cyc;
      q_addr.push_back(int'(bus.mem_addr));
      issued++;
    end
    if (bus.out_valid && first_vld < 0) first_vld = cyc;
    if (m_x) begin
      q_dat.push_back(bus.out_data);
      q_sb.push_back(bus.out_sb);
      q_last.push_back(bus.out_last);
      xferred++;
      last_edge = cyc + 1;
    end
    if (bus.done) begin
      done_cnt++;
      done_edge = cyc + 1;
    end
    if (clr_tok != m_tok) begin
      m_tok = clr_tok;
      q_dat.delete(); q_sb.delete(); q_last.delete(); q_addr.delete();
      first_re = -1; first_vld = -1; last_edge = -1; done_edge = -1;
      done_cnt = 0; issued = 0; xferred = 0; ovf = 0; unstable = 0; m_hold = 1'b0;
    end
  end

  int e_addr [$];

  function automatic void mk_exp(input int n, input bit inv);
    e_addr.delete();
    if (!inv) begin
      for (int a = 0; a < n; a++) e_addr.push_back(a);
    end else begin
      for (int a = 0; a < n; a += 2) e_addr.push_back(a);
      for (int a = 1; a < n; a += 2) e_addr.push_back(a);
    end
  endfunction

  task automatic clr();
    clr_tok++;
    @(negedge clk);
    #1;
  endtask

  task automatic kick(input logic [AW-1:0] l, input bit inv);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.len = l; bus.fwd_inv = inv;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b0; bus.len = ~l; bus.fwd_inv = ~inv;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done_cnt > 0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [38:0] v;
    #3 rst_n = 1'b0;
    #1;
    v = {bus.mem_re, bus.mem_addr, bus.out_valid, bus.out_data, bus.out_sb, bus.out_last, bus.busy, bus.done};
    n_cmp++;
    if (v !== 39'd0) begin n_bad++; $display("FAIL reset_async got %h want 0", v); end
    repeat (2) @(posedge clk);
    #1;
    v = {bus.mem_re, bus.mem_addr, bus.out_valid, bus.out_data, bus.out_sb, bus.out_last, bus.busy, bus.done};
    n_cmp++;
    if (v !== 39'd0) begin n_bad++; $display("FAIL reset_held got %h want 0", v); end
    rst_n = 1'b1;
  endtask

  task automatic test_row(input string nm, input logic [AW-1:0] l, input bit inv,
                          input int mode, input bit chk_lat);
    int n;
    bit to;
    n = (l == '0) ? 128 : int'(l);
    rdy_mode = mode;
    clr();
    mk_exp(n, inv);
    kick(l, inv);
    wait_done(n * 8 + 100, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL %s_timeout got no done want done", nm); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q_dat.size() !== n) begin n_bad++; $display("FAIL %s_beats got %0d want %0d", nm, q_dat.size(), n); end
    n_cmp++;
    if (q_addr.size() !== n) begin n_bad++; $display("FAIL %s_reads got %0d want %0d", nm, q_addr.size(), n); end
    for (int i = 0; i < n && i < q_dat.size(); i++) begin
      n_cmp++;
      if ({q_dat[i], q_sb[i], q_last[i]} !== {pat(e_addr[i]), 1'(e_addr[i] & 1), 1'(i == n - 1)}) begin
        n_bad++;
        $display("FAIL %s_beat%0d got %h/%b/%b want %h/%b/%b", nm, i, q_dat[i], q_sb[i], q_last[i],
                 pat(e_addr[i]), 1'(e_addr[i] & 1), 1'(i == n - 1));
      end
    end
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      n_cmp++;
      if (q_addr[i] !== e_addr[i]) begin
        n_bad++; $display("FAIL %s_addr%0d got %0d want %0d", nm, i, q_addr[i], e_addr[i]);
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL %s_done_cnt got %0d want 1", nm, done_cnt); end
    n_cmp++;
    if (ovf !== 0) begin n_bad++; $display("FAIL %s_outstanding got %0d want 0", nm, ovf); end
    n_cmp++;
    if (unstable !== 0) begin n_bad++; $display("FAIL %s_stable got %0d want 0", nm, unstable); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_end got %b want 0", nm, bus.busy); end
    if (chk_lat) begin
      n_cmp++;
      if (first_re - t0 !== 0) begin n_bad++; $display("FAIL %s_first_re got %0d want 0", nm, first_re - t0); end
      n_cmp++;
      if (first_vld - t0 !== 2) begin n_bad++; $display("FAIL %s_first_vld got %0d want 2", nm, first_vld - t0); end
      n_cmp++;
      if (last_edge - t0 !== n + 2) begin n_bad++; $display("FAIL %s_last_edge got %0d want %0d", nm, last_edge - t0, n + 2); end
      n_cmp++;
      if (done_edge - t0 !== n + 3) begin n_bad++; $display("FAIL %s_done_edge got %0d want %0d", nm, done_edge - t0, n + 3); end
    end
  endtask

  task automatic test_stall_fill();
    bit to;
    rdy_mode = 2;
    clr();
    kick(7'd5, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (issued !== 2) begin n_bad++; $display("FAIL fill_issued got %0d want 2", issued); end
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_sb} !== {1'b1, pat(0), 1'b0}) begin
      n_bad++; $display("FAIL fill_head got %b/%h/%b want 1/%h/0", bus.out_valid, bus.out_data, bus.out_sb, pat(0));
    end
    rdy_mode = 0;
    wait_done(200, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL fill_timeout got no done want done"); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q_dat.size() !== 5) begin n_bad++; $display("FAIL fill_beats got %0d want 5", q_dat.size()); end
    for (int i = 0; i < 5 && i < q_dat.size(); i++) begin
      n_cmp++;
      if ({q_dat[i], q_sb[i], q_last[i]} !== {pat(i), 1'(i & 1), 1'(i == 4)}) begin
        n_bad++; $display("FAIL fill_beat%0d got %h/%b/%b want %h/%b/%b", i, q_dat[i], q_sb[i], q_last[i],
                          pat(i), 1'(i & 1), 1'(i == 4));
      end
    end
    n_cmp++;
    if ({ovf, unstable} !== 64'd0) begin n_bad++; $display("FAIL fill_flow got ovf=%0d unstable=%0d want 0/0", ovf, unstable); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit hit;
    logic [38:0] v;
    rdy_mode = 0;
    clr();
    kick(7'd16, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk); #2;
      if (xferred >= 5) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL rstmid_reach got %0d beats want 5", xferred); end
    rst_n = 1'b0;
    #1;
    v = {bus.mem_re, bus.mem_addr, bus.out_valid, bus.out_data, bus.out_sb, bus.out_last, bus.busy, bus.done};
    n_cmp++;
    if (v !== 39'd0) begin n_bad++; $display("FAIL rstmid_async got %h want 0", v); end
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    clr();
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if ({issued, xferred, first_vld} !== {32'd0, 32'd0, -32'sd1}) begin
      n_bad++; $display("FAIL rstmid_quiet got reads=%0d beats=%0d want 0/0", issued, xferred);
    end
    clr();
    kick(7'd2, 1'b0);
    wait_done(100, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL rstmid_timeout got no done want done"); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q_dat.size() !== 2) begin n_bad++; $display("FAIL rstmid_beats got %0d want 2", q_dat.size()); end
    for (int i = 0; i < 2 && i < q_dat.size(); i++) begin
      n_cmp++;
      if ({q_dat[i], q_sb[i], q_last[i]} !== {pat(i), 1'(i & 1), 1'(i == 1)}) begin
        n_bad++; $display("FAIL rstmid_beat%0d got %h/%b/%b want %h/%b/%b", i, q_dat[i], q_sb[i], q_last[i],
                          pat(i), 1'(i & 1), 1'(i == 1));
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL rstmid_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    bit to;
    bit found;
    rdy_mode = 0;
    clr();
    kick(7'd4, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
    // This request lands while busy and must be dropped.
    bus.start = 1'b1; bus.len = 7'd2; bus.fwd_inv = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL b2b_done1 got no done want done"); end
    n_cmp++;
    if ({q_dat.size(), q_addr.size()} !== {32'd4, 32'd4}) begin
      n_bad++; $display("FAIL b2b_row1 got %0d beats/%0d reads want 4/4", q_dat.size(), q_addr.size());
    end
    for (int i = 0; i < 4 && i < q_dat.size(); i++) begin
      n_cmp++;
      if ({q_dat[i], q_sb[i], q_last[i]} !== {pat(i), 1'(i & 1), 1'(i == 3)}) begin
        n_bad++; $display("FAIL b2b_row1_beat%0d got %h/%b/%b want %h/%b/%b", i, q_dat[i], q_sb[i], q_last[i],
                          pat(i), 1'(i & 1), 1'(i == 3));
      end
    end
    // Request raised during the done cycle must be taken.
    bus.start = 1'b1; bus.len = 7'd3; bus.fwd_inv = 1'b0;
    clr();
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b0;
    wait_done(100, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL b2b_timeout got no done want done"); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q_dat.size() !== 3) begin n_bad++; $display("FAIL b2b_row2 got %0d beats want 3", q_dat.size()); end
    for (int i = 0; i < 3 && i < q_dat.size(); i++) begin
      n_cmp++;
      if ({q_dat[i], q_sb[i], q_last[i]} !== {pat(i), 1'(i & 1), 1'(i == 2)}) begin
        n_bad++; $display("FAIL b2b_row2_beat%0d got %h/%b/%b want %h/%b/%b", i, q_dat[i], q_sb[i], q_last[i],
                          pat(i), 1'(i & 1), 1'(i == 2));
      end
    end
    n_cmp++;
    if (first_vld - t0 !== 2) begin n_bad++; $display("FAIL b2b_first_vld got %0d want 2", first_vld - t0); end
    n_cmp++;
    if (last_edge - t0 !== 5) begin n_bad++; $display("FAIL b2b_last_edge got %0d want 5", last_edge - t0); end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL b2b_done2 got %0d want 1", done_cnt); end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.len     = '0;
    bus.fwd_inv = 1'b0;
    for (int i = 0; i < 128; i++) ram[i] = pat(i);
    test_reset();
    test_row("nat8",    7'd8,  1'b0, 0, 1'b1);
    test_row("deint7",  7'd7,  1'b1, 0, 1'b1);
    test_row("deint1",  7'd1,  1'b1, 0, 1'b1);
    test_row("deint2",  7'd2,  1'b1, 0, 1'b1);
    test_row("deint128", 7'd0, 1'b1, 0, 1'b1);
    test_row("nat128",  7'd0,  1'b0, 0, 1'b1);
    test_row("rand16",  7'd16, 1'b0, 1, 1'b0);
    test_row("rand16i", 7'd16, 1'b1, 1, 1'b0);
    test_stall_fill();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
